// File: rtl/seq_match_window_if.sv
// seq_match_window_if
//   Bundles the sample input, the enable level and the valid/ready report
//   port of seq_match_window.
//   master : the statistics collector (drives report_valid and results)
//   slave  : the upstream/host side (drives match_in, enable, report_ready)
//   Signals:
//     match_in     recognizer match bit, sampled each edge while counting
//     enable       1 lets windows start/continue, 0 aborts or idles
//     report_valid a completed window's results are presented
//     report_ready host accepts the report when valid & ready
//     match_count  asserted-sample count of the last reported window
//     max_run      longest consecutive asserted run of that window
//     overflow     count or run saturated in that window
interface seq_match_window_if #(
    parameter int unsigned CW = 8
);
    logic          match_in;
    logic          enable;
    logic          report_valid;
    logic          report_ready;
    logic [CW-1:0] match_count;
    logic [CW-1:0] max_run;
    logic          overflow;

    modport master (
        input  match_in,
        input  enable,
        input  report_ready,
        output report_valid,
        output match_count,
        output max_run,
        output overflow
    );

    modport slave (
        output match_in,
        output enable,
        output report_ready,
        input  report_valid,
        input  match_count,
        input  max_run,
        input  overflow
    );
endinterface

// File: rtl/seq_match_window.sv
// seq_match_window
//   Collects statistics on a one-bit match stream over fixed windows of
//   WINDOW samples: number of asserted samples and longest run of
//   consecutive asserted samples, both saturating at 2^CW-1. Each finished
//   window is offered on a valid/ready report port; results stay registered
//   until the next window completes.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-high; clears all state and outputs
//     bus    seq_match_window_if master modport (sample, enable, report)
module seq_match_window #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CW     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    seq_match_window_if.master     bus
);

    localparam int unsigned   IW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [IW-1:0] LAST = IW'(WINDOW - 1);
    localparam logic [CW-1:0] MAXV = '1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REPORT
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] run_q, run_d;
    logic [CW-1:0] best_q, best_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] res_cnt_q, res_cnt_d;
    logic [CW-1:0] res_run_q, res_run_d;
    logic          res_ovf_q, res_ovf_d;

    // Statistics as they would be after taking the current sample
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] run_nxt;
    logic [CW-1:0] best_nxt;
    logic          ovf_nxt;
    logic          clear;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            run_q     <= '0;
            best_q    <= '0;
            ovf_q     <= 1'b0;
            res_cnt_q <= '0;
            res_run_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            best_q    <= best_d;
            ovf_q     <= ovf_d;
            res_cnt_q <= res_cnt_d;
            res_run_q <= res_run_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    always_comb begin
        cnt_nxt = cnt_q;
        run_nxt = '0;
        ovf_nxt = ovf_q;
        if (bus.match_in) begin
            // An increment attempted at full scale is what flags overflow
            if (cnt_q == MAXV) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
            if (run_q == MAXV) begin
                ovf_nxt = 1'b1;
                run_nxt = run_q;
            end else begin
                run_nxt = run_q + 1'b1;
            end
        end
        best_nxt = (run_nxt > best_q) ? run_nxt : best_q;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        best_d    = best_q;
        ovf_d     = ovf_q;
        res_cnt_d = res_cnt_q;
        res_run_d = res_run_q;
        res_ovf_d = res_ovf_q;
        clear     = 1'b0;

        unique case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (bus.enable) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!bus.enable) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == LAST) begin
                    // Final sample goes straight into the result registers
                    res_cnt_d = cnt_nxt;
                    res_run_d = best_nxt;
                    res_ovf_d = ovf_nxt;
                    clear     = 1'b1;
                    state_d   = REPORT;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    cnt_d  = cnt_nxt;
                    run_d  = run_nxt;
                    best_d = best_nxt;
                    ovf_d  = ovf_nxt;
                end
            end
            REPORT: begin
                clear = 1'b1;
                if (bus.report_ready) begin
                    state_d = bus.enable ? COUNT : IDLE;
                end
            end
            default: begin
                clear   = 1'b1;
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            idx_d  = '0;
            cnt_d  = '0;
            run_d  = '0;
            best_d = '0;
            ovf_d  = 1'b0;
        end
    end

    assign bus.report_valid = (state_q == REPORT);
    assign bus.match_count  = res_cnt_q;
    assign bus.max_run      = res_run_q;
    assign bus.overflow     = res_ovf_q;

endmodule

// File: tb/tb_seq_match_window.sv
module tb_seq_match_window;

    localparam int W = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    seq_match_window_if #(.CW(8)) bus8 ();
    seq_match_window_if #(.CW(3)) bus3 ();

    seq_match_window #(.WINDOW(W), .CW(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8.master)
    );

    seq_match_window #(.WINDOW(W), .CW(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3.master)
    );

    int checks = 0;
    int errors = 0;

    // Expected values of the last reported window for each instance
    int e8c = 0, e8r = 0, e3c = 0, e3r = 0;
    bit e8o = 1'b0, e3o = 1'b0;

    task automatic drive(input logic m, input logic en, input logic rdy);
        bus8.match_in     = m;
        bus8.enable       = en;
        bus8.report_ready = rdy;
        bus3.match_in     = m;
        bus3.enable       = en;
        bus3.report_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic vexp);
        chk({tag, " valid8"}, 32'(bus8.report_valid), 32'(vexp));
        chk({tag, " count8"}, 32'(bus8.match_count), 32'(e8c));
        chk({tag, " run8"},   32'(bus8.max_run), 32'(e8r));
        chk({tag, " ovf8"},   32'(bus8.overflow), 32'(e8o));
        chk({tag, " valid3"}, 32'(bus3.report_valid), 32'(vexp));
        chk({tag, " count3"}, 32'(bus3.match_count), 32'(e3c));
        chk({tag, " run3"},   32'(bus3.max_run), 32'(e3r));
        chk({tag, " ovf3"},   32'(bus3.overflow), 32'(e3o));
    endtask

    // Window statistics straight from the sample list
    task automatic calc(input logic [W-1:0] p, input int cw,
                        output int c, output int r, output bit o);
        int cur = 0;
        int mx  = (1 << cw) - 1;
        c = 0;
        r = 0;
        for (int i = 0; i < W; i++) begin
            if (p[i]) begin
                c++;
                cur++;
                if (cur > r) r = cur;
            end else begin
                cur = 0;
            end
        end
        o = (c > mx) || (r > mx);
        if (c > mx) c = mx;
        if (r > mx) r = mx;
    endtask

    // Called just after an edge; reset asserts and releases between edges
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        e8c = 0; e8r = 0; e8o = 1'b0;
        e3c = 0; e3r = 0; e3o = 1'b0;
        chk_all(tag, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_window(input string tag, input logic [W-1:0] p,
                              input bit from_idle, input int stall,
                              input bit stay, input bit rst_in_report);
        logic early_rdy;
        early_rdy = (stall == 0) && !rst_in_report;
        if (from_idle) begin
            drive(1'($urandom), 1'b1, 1'b0);
            tick();
            chk_all({tag, " e0"}, 1'b0);
        end
        for (int i = 0; i < W; i++) begin
            drive(p[i], 1'b1, early_rdy);
            tick();
            if (i < W - 1) chk_all({tag, " counting"}, 1'b0);
        end
        calc(p, 8, e8c, e8r, e8o);
        calc(p, 3, e3c, e3r, e3o);
        chk_all({tag, " report"}, 1'b1);
        if (rst_in_report) begin
            pulse_reset({tag, " rst_in_report"});
            return;
        end
        for (int s = 0; s < stall; s++) begin
            drive(1'($urandom), 1'($urandom), 1'b0);
            tick();
            chk_all({tag, " stall"}, 1'b1);
        end
        drive(1'($urandom), stay, 1'b1);
        tick();
        chk_all({tag, " after_hs"}, 1'b0);
    endtask

    initial begin
        logic [7:0]   base;
        logic [W-1:0] pat;
        bit           idle;
        bit           stay;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        #2;
        chk_all("reset", 1'b0);
        #10;
        reset = 1'b0;
        tick();
        chk_all("idle", 1'b0);

        // 1,1,0,1,1,1,0,0 twice: count 10, run 3; ready already high
        base = 8'b0011_1011;
        pat  = {base, base};
        run_window("pattern", pat, 1'b1, 0, 1'b1, 1'b0);

        // Back-to-back all ones: run ending on the last sample
        pat = '1;
        run_window("all_ones", pat, 1'b0, 0, 1'b0, 1'b0);

        // Ready stalled five cycles with match toggling in REPORT
        pat = W'($urandom);
        run_window("stall5", pat, 1'b1, 5, 1'b0, 1'b0);
        pat = W'($urandom);
        run_window("post_stall", pat, 1'b1, 0, 1'b0, 1'b0);

        // Abort after 8 samples
        drive(1'($urandom), 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1);
        tick();
        chk_all("abort", 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'b0, 1'($urandom));
            tick();
            chk_all("abort idle", 1'b0);
        end
        pat = W'($urandom);
        run_window("after_abort", pat, 1'b1, 1, 1'b0, 1'b0);

        // Reset mid-window, then a fresh window
        drive(1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        pulse_reset("rst_mid");
        pat = W'($urandom);
        run_window("after_rst_mid", pat, 1'b1, 0, 1'b0, 1'b0);

        // Reset during REPORT, then a fresh window
        pat = '1;
        run_window("rst_report", pat, 1'b1, 0, 1'b0, 1'b1);
        pat = W'($urandom);
        run_window("after_rst_report", pat, 1'b1, 2, 1'b0, 1'b0);

        // Random windows with random stalls and enable continuity
        idle = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pat  = W'($urandom);
            stay = 1'($urandom);
            run_window("random", pat, idle, int'($urandom_range(3, 0)), stay, 1'b0);
            idle = !stay;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_match_window.md
# seq_match_window

Windowed statistics collector that sits directly downstream of the Moore sequence recognizer and consumes its one-bit match output. Over a fixed window of WINDOW clock cycles it counts the cycles with match asserted and tracks the longest run of consecutive asserted cycles. It then presents both results on a valid/ready report port for a host or logger.

## Interface
- WINDOW, 16: samples per window; legal range 2..2^16.
- CW, 8: width of the count and run outputs.
- clock  input  1  rising-edge clock shared with the recognizer.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- match_in  input  1  recognizer match output, sampled on every rising clock edge while counting.
- enable  input  1  level; 1 allows windows to start and continue; 0 aborts or idles.
- report_valid  output  1  result is available; held until accepted.
- report_ready  input  1  consumer accepts the report on an edge where valid&ready = 1.
- match_count  output  CW  number of samples with match_in=1 in the last reported window (saturating).
- max_run  output  CW  longest run of consecutive match_in=1 samples in the last reported window (saturating).
- overflow  output  1  1 if match_count or max_run saturated in the last reported window.

## Operation
- State machine has three states: IDLE, COUNT, REPORT. Reset state is IDLE.
- IDLE: internal counters are held at 0. On an edge with enable=1, go to COUNT. That edge samples nothing.
- COUNT: each edge samples match_in and advances the sample index from 0 to WINDOW-1.
  - match_in=1: the running count increments and the current run increments. Both saturate at 2^CW-1; saturation sets an internal overflow flag.
  - match_in=0: the current run is cleared to 0.
  - The best run is the maximum of the previous best and the updated current run. The updated current run includes the sample taken on that same edge.
- On the edge that takes sample WINDOW-1:
  - Load the final count, best run and overflow into the output registers. The last sample is included.
  - Go to REPORT.
- COUNT with enable=0 at an edge: abort, discard partial results, go to IDLE. Output registers are unchanged and no report is issued.
- REPORT:
  - report_valid=1.
  - match_in is ignored; samples taken in REPORT are lost by design.
  - enable has no effect until the handshake completes.
  - On an edge with report_ready=1: if enable=1, clear internal counters and go to COUNT; otherwise go to IDLE.
- match_count, max_run and overflow are registered and hold the last reported window until the next window completes.

## Timing
- Reset values: report_valid=0, match_count=0, max_run=0, overflow=0, state IDLE. Reset asserted mid-window or mid-report abandons everything asynchronously.
- Latency: let edge E0 be the enable=1 edge in IDLE. Samples are taken at E1..E_WINDOW. report_valid is high in the cycle after E_WINDOW, and the outputs are valid in that same cycle.
- Handshake:
  - Once report_valid rises, it stays high and the outputs stay stable until an edge with report_ready=1.
  - report_valid falls in the cycle after that edge.
  - With enable held high, the next window's first sample is taken on the edge after the handshake edge. Back-to-back period is therefore WINDOW+1 edges plus ready stall cycles.
- report_ready=1 already high when valid rises completes the handshake on the first REPORT edge.
- Sample index width is ceil(log2(WINDOW)). The wrap from WINDOW-1 does not re-enter COUNT without passing through REPORT.

## Test plan
- Defaults, enable held high, report_ready=1, match_in pattern 1,1,0,1,1,1,0,0 repeated twice -> first report match_count=10, max_run=3, overflow=0, report_valid high in the cycle after edge E16.
- Defaults, match_in=1 for all 16 samples -> match_count=16, max_run=16, overflow=0. A run ending on the last sample must be counted.
- CW=3, WINDOW=16, match_in=1 for all samples -> match_count=7, max_run=7, overflow=1.
- report_ready held 0 for 5 cycles after valid -> report_valid and outputs stable for all 5 cycles. match_in toggling during REPORT does not affect the next window's counts.
- enable dropped after 8 samples -> state returns to IDLE, no report_valid, outputs keep the prior window's values. Re-enabling starts a fresh 16-sample window.
- reset pulsed mid-window and again during REPORT -> all outputs 0 immediately (no clock edge needed), report_valid=0. The next window counts from zero.
